mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the data-memory side of the single-cycle core. It consumes the core's store bus (MemWrite, DataAdr, WriteData) in parallel with dmem. Byte stores to the TX address are queued in a small FIFO and serialised 8N1 on txd. A status word is returned combinationally for loads from the status address, for muxing into the core's ReadData.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/mmio_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped UART transmitter.
//   - Default word addresses of the TX data port and the status register.
//   - Bit positions of the fields inside the status word.
//   - UART transmitter state encoding.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEFAULT     = 32'h0000_FF00;
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h0000_FF04;

    // Status word layout
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_BUSY      = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a fall-through head (dout always shows
// the oldest entry while not empty).
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset (pointers/count cleared)
//   push   in   write din this cycle
//   pop    in   remove the head this cycle
//   din    in   [WIDTH-1:0] write data
//   dout   out  [WIDTH-1:0] head entry (combinational from storage)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  [$clog2(DEPTH):0] number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's store bus.
// Byte stores to TX_ADDR are queued in a FIFO and shifted out LSB first.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   MemWrite   in   store strobe from core
//   DataAdr    in   [31:0] load/store address
//   WriteData  in   [31:0] store data, bits [7:0] used
//   sel        out  combinational, DataAdr hits TX_ADDR or STATUS_ADDR
//   rd_data    out  [31:0] combinational status word at STATUS_ADDR, else 0
//   txd        out  serial line, idle high (registered)
//   busy       out  high while a frame is on the line (registered)
// Status word: [0] full, [1] empty, [2] overflow (sticky), [3] busy,
// [7:4] FIFO count. A store to STATUS_ADDR clears overflow.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
    parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        txd,
    output logic        busy
);

    localparam int                BW        = $clog2(CLKS_PER_BIT);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // ---------------- address decode ----------------
    logic hit_tx;
    logic hit_status;
    logic tx_push;
    logic ovf_clr;

    assign hit_tx     = (DataAdr == TX_ADDR);
    assign hit_status = (DataAdr == STATUS_ADDR);
    assign sel        = hit_tx || hit_status;
    assign tx_push    = MemWrite && hit_tx;
    assign ovf_clr    = MemWrite && hit_status;

    // Only the low byte of a store is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    // ---------------- transmit queue ----------------
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- state ----------------
    uart_state_t   state_q,   state_d;
    logic [BW-1:0] baud_q,    baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic          txd_q,     txd_d;
    logic          busy_q,    busy_d;
    logic          ovf_q,     ovf_d;

    logic baud_last;
    logic ovf_set;

    assign baud_last = (baud_q == BAUD_LAST);
    // A push into a full FIFO is dropped unless the same edge pops the head.
    assign ovf_set   = tx_push && fifo_full && !fifo_pop;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    baud_d   = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // txd is registered, so the next bit is taken
                        // from shift_q[1] while the register shifts.
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

    // ---------------- status word ----------------
    // The count field is four bits wide; with a 16-deep FIFO a full queue
    // reads back count 0 and is identified by the full bit instead.
    logic [31:0] status;

    always_comb begin
        status                                = '0;
        status[ST_FULL]                       = fifo_full;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_OVF]                        = ovf_q;
        status[ST_BUSY]                       = busy_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    assign rd_data = hit_status ? status : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int          CPB = 4;
    localparam logic [31:0] TXA = 32'h0000_FF00;
    localparam logic [31:0] STA = 32'h0000_FF04;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        sel;
    logic [31:0] rd_data;
    logic        txd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .sel       (sel),
        .rd_data   (rd_data),
        .txd       (txd),
        .busy      (busy)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        DataAdr = STA;
        #1;
        v = rd_data;
        DataAdr = 32'h0;
    endtask

    // Waits for a start bit, then samples each bit slot at the same phase.
    // idle = number of high samples seen before the falling edge.
    task automatic rx_frame(output logic [7:0] data, output logic start_ok,
                            output logic stop_ok, output int idle, output bit to);
        to = 1'b0; idle = 0; data = 8'h00; start_ok = 1'b0; stop_ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txd === 1'b0) break;
            idle++;
        end
        if (txd !== 1'b0) begin
            to = 1'b1;
            return;
        end
        repeat (2) @(negedge clk);
        start_ok = (txd === 1'b0);
        repeat (CPB - 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            data[b] = txd;
            repeat (CPB) @(negedge clk);
        end
        stop_ok = (txd === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] st;
        #12;
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_outputs: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        DataAdr = STA;
        #1;
        total++;
        if (sel !== 1'b1 || rd_data !== 32'h0000_0002) begin
            bad++;
            $display("FAIL reset_status: got sel=%b rd=%h want sel=1 rd=00000002", sel, rd_data);
        end
        DataAdr = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        $display("reset released");

        // abort a frame partway through its data bits
        do_store(TXA, 32'h0000_00A5);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_preframe_busy: got %b want 1", busy);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_midframe: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        read_status(st);
        total++;
        if (st !== 32'h0000_0002) begin
            bad++;
            $display("FAIL reset_midframe_status: got %h want 00000002", st);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_no_resume: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       exp_txd;
        int         slot;
        d = 8'hA5;
        do_store(TXA, 32'h0000_00A5);
        // between push edge N and pop edge N+1 the line is still idle
        @(negedge clk);
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL single_latency: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            slot = i / CPB;
            if (slot == 0)      exp_txd = 1'b0;
            else if (slot == 9) exp_txd = 1'b1;
            else                exp_txd = d[slot - 1];
            total++;
            if ({txd, busy} !== {exp_txd, 1'b1}) begin
                bad++;
                $display("FAIL single_cycle%0d: got txd=%b busy=%b want txd=%b busy=1",
                         i, txd, busy, exp_txd);
            end
        end
        @(negedge clk);
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL single_end: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        $display("test_single: byte a5 frame checked");
    endtask

    task automatic test_fill_overflow();
        logic [31:0] st;
        logic [7:0]  data;
        logic        s_ok, p_ok;
        int          idle;
        bit          to;
        do_store(TXA, 32'h0000_0010);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            do_store(TXA, 32'h0000_0011 + 32'(k));
        end
        read_status(st);
        total++;
        if (st !== 32'h0000_004D) begin
            bad++;
            $display("FAIL fill_status: got %h want 0000004d", st);
        end
        do_store(STA, 32'h0);
        read_status(st);
        total++;
        if (st !== 32'h0000_0049) begin
            bad++;
            $display("FAIL ovf_clear: got %h want 00000049", st);
        end
        // let the 0x10 frame finish
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL fill_wait_idle: got busy=%b want 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            rx_frame(data, s_ok, p_ok, idle, to);
            total++;
            if (to || data !== 8'h11 + 8'(k) || !s_ok || !p_ok) begin
                bad++;
                $display("FAIL fill_frame%0d: got data=%h start=%b stop=%b timeout=%0b want data=%h",
                         k, data, s_ok, p_ok, to, 8'h11 + 8'(k));
            end else begin
                $display("fill frame %0d: %h", k, data);
            end
        end
        repeat (6) @(negedge clk);
        read_status(st);
        total++;
        if (st !== 32'h0000_0002) begin
            bad++;
            $display("FAIL fill_drained: got %h want 00000002", st);
        end
    endtask

    task automatic test_full_simul();
        logic [31:0] st;
        logic [7:0]  data;
        logic        s_ok, p_ok;
        int          idle;
        bit          to;
        do_store(TXA, 32'h0000_0020);
        for (int k = 1; k <= 4; k++) begin
            do_store(TXA, 32'h0000_0020 + 32'(k));
        end
        read_status(st);
        total++;
        if (st !== 32'h0000_0049) begin
            bad++;
            $display("FAIL simul_prefill: got %h want 00000049", st);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_wait_idle: got busy=%b want 0", busy);
        end
        // this edge pops 0x21 while pushing 0x25 into the full FIFO
        do_store(TXA, 32'h0000_0025);
        read_status(st);
        total++;
        if (st !== 32'h0000_0049) begin
            bad++;
            $display("FAIL simul_push_pop: got %h want 00000049", st);
        end
        for (int k = 1; k <= 5; k++) begin
            rx_frame(data, s_ok, p_ok, idle, to);
            total++;
            if (to || data !== 8'h20 + 8'(k) || !s_ok || !p_ok) begin
                bad++;
                $display("FAIL simul_frame%0d: got data=%h start=%b stop=%b timeout=%0b want data=%h",
                         k, data, s_ok, p_ok, to, 8'h20 + 8'(k));
            end else begin
                $display("simul frame %0d: %h", k, data);
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        logic [7:0] got_b [3];
        logic       s_ok [3];
        logic       p_ok [3];
        int         idle [3];
        bit         to   [3];
        logic [31:0] st;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    do_store(TXA, {24'h0, exp_b[k]});
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    rx_frame(got_b[k], s_ok[k], p_ok[k], idle[k], to[k]);
                end
            end
        join
        for (int k = 0; k < 3; k++) begin
            total++;
            if (to[k] || got_b[k] !== exp_b[k] || !s_ok[k] || !p_ok[k]) begin
                bad++;
                $display("FAIL b2b_frame%0d: got data=%h start=%b stop=%b timeout=%0b want data=%h",
                         k, got_b[k], s_ok[k], p_ok[k], to[k], exp_b[k]);
            end else begin
                $display("b2b frame %0d: %h idle_before=%0d", k, got_b[k], idle[k]);
            end
        end
        // CPB-1 remaining stop cycles plus exactly one idle cycle
        for (int k = 1; k < 3; k++) begin
            total++;
            if (idle[k] != CPB) begin
                bad++;
                $display("FAIL b2b_gap%0d: got %0d high samples want %0d", k, idle[k], CPB);
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_end: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        read_status(st);
        total++;
        if (st !== 32'h0000_0002) begin
            bad++;
            $display("FAIL b2b_empty: got %h want 00000002", st);
        end
    endtask

    task automatic test_decode();
        logic [31:0] st;
        DataAdr = 32'h0000_FF08;
        #1;
        total++;
        if (sel !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL decode_ff08: got sel=%b rd=%h want sel=0 rd=0", sel, rd_data);
        end
        DataAdr = 32'h0000_0100;
        #1;
        total++;
        if (sel !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL decode_0100: got sel=%b rd=%h want sel=0 rd=0", sel, rd_data);
        end
        DataAdr = TXA;
        #1;
        total++;
        if (sel !== 1'b1 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL decode_tx: got sel=%b rd=%h want sel=1 rd=0", sel, rd_data);
        end
        DataAdr = STA;
        #1;
        total++;
        if (sel !== 1'b1) begin
            bad++;
            $display("FAIL decode_status_sel: got %b want 1", sel);
        end
        DataAdr = 32'h0;
        @(negedge clk);
        do_store(32'h0000_FF08, 32'h0000_0077);
        do_store(32'h0000_0100, 32'h0000_0088);
        repeat (4) @(negedge clk);
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL decode_no_tx: got txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        read_status(st);
        total++;
        if (st !== 32'h0000_0002) begin
            bad++;
            $display("FAIL decode_status: got %h want 00000002", st);
        end
        $display("test_decode done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_simul();
        test_back_to_back();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
